rx_slicer_ber_qi: RTL and testbench

- Receive-side checker downstream of the I/Q polyphase transmit filter.
- Decimates the oversampled I and Q filter outputs S(NB_INPUT, NB_INPUT-1) to one sample per symbol at a selectable phase.
- Slices each sample to a hard bit and self-synchronises a PRBS9 checker per channel.
- Reports lock status plus error and bit counters per channel for link BER measurement in simulation and on hardware.

---
 rtl/rx_slicer_ber_qi_pkg.sv | 23 ++
 rtl/rx_slicer_ber_qi_checker.sv | 116 +++++++++++
 rtl/rx_slicer_ber_qi.sv | 112 +++++++++++
 tb/tb_rx_slicer_ber_qi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_slicer_ber_qi_pkg.sv
// rtl/rx_slicer_ber_qi_pkg.sv - shared constants and types for the I/Q slicer BER checker
// Contents:
//   PRBS_TAP_A/B  : PRBS9 polynomial taps (x^9 + x^5 + 1)
//   DEF_WINDOW    : default bits per lock/loss evaluation window
//   DEF_LOCK_THR  : default max window errors to declare lock
//   DEF_LOSS_THR  : default window errors above which lock is dropped
//   chk_state_t   : checker FSM state encoding
package rx_slicer_ber_qi_pkg;

  localparam int PRBS_TAP_A   = 9;
  localparam int PRBS_TAP_B   = 5;

  localparam int DEF_WINDOW   = 128;
  localparam int DEF_LOCK_THR = 4;
  localparam int DEF_LOSS_THR = 32;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

endpackage

// File: rtl/rx_slicer_ber_qi_checker.sv
// rtl/rx_slicer_ber_qi_checker.sv - self-synchronising PRBS9 checker with windowed lock and BER counters
// Ports:
//   clock, i_reset   : clock, synchronous active-high reset
//   i_enable         : global enable, all state holds when low
//   i_bit            : received hard bit
//   i_bit_valid      : i_bit is meaningful this cycle
//   i_clear          : zeroes the error/bit counters only
//   o_lock           : checker locked
//   o_err_count      : saturating mismatch count while locked
//   o_bit_count      : saturating compared-bit count while locked
module prbs9_sync_checker
  import rx_slicer_ber_qi_pkg::*;
#(
  parameter int NB_COUNT = 32,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int LOCK_THR = DEF_LOCK_THR,
  parameter int LOSS_THR = DEF_LOSS_THR
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_bit,
  input  logic                i_bit_valid,
  input  logic                i_clear,
  output logic                o_lock,
  output logic [NB_COUNT-1:0] o_err_count,
  output logic [NB_COUNT-1:0] o_bit_count
);

  localparam int NB_WIN = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [NB_WIN-1:0] WIN_LAST  = NB_WIN'(WINDOW - 1);
  localparam logic [NB_WIN:0]   LOCK_LIM  = (NB_WIN + 1)'(LOCK_THR);
  localparam logic [NB_WIN:0]   LOSS_LIM  = (NB_WIN + 1)'(LOSS_THR);
  localparam logic [3:0]        LOAD_LAST = 4'(PRBS_TAP_A - 1);

  chk_state_t                r_state;
  chk_state_t                w_state_next;
  logic [PRBS_TAP_A-1:0]     r_lfsr;
  logic [3:0]                r_load_cnt;
  logic [NB_WIN-1:0]         r_win_cnt;
  logic [NB_WIN:0]           r_win_err;
  logic [NB_COUNT-1:0]       r_err_count;
  logic [NB_COUNT-1:0]       r_bit_count;

  logic                      w_adv;
  logic                      w_pred;
  logic                      w_miss;
  logic                      w_win_end;
  logic [NB_WIN:0]           w_win_err_tot;

  assign w_adv         = i_enable && i_bit_valid;
  assign w_pred        = r_lfsr[PRBS_TAP_A-1] ^ r_lfsr[PRBS_TAP_B-1];
  assign w_miss        = i_bit ^ w_pred;
  assign w_win_end     = (r_win_cnt == WIN_LAST);
  // Error total including the bit being compared right now.
  assign w_win_err_tot = r_win_err + {{NB_WIN{1'b0}}, w_miss};

  always_comb begin
    w_state_next = r_state;
    if (w_adv) begin
      unique case (r_state)
        ST_LOAD:   if (r_load_cnt == LOAD_LAST) w_state_next = ST_CHECK;
        ST_CHECK:  if (w_win_end) w_state_next = (w_win_err_tot <= LOCK_LIM) ? ST_LOCKED : ST_LOAD;
        ST_LOCKED: if (w_win_end && (w_win_err_tot > LOSS_LIM)) w_state_next = ST_LOAD;
        default:   w_state_next = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state     <= ST_LOAD;
      r_lfsr      <= '0;
      r_load_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else if (i_enable) begin
      r_state <= w_state_next;
      if (w_adv) begin
        if (r_state == ST_LOAD) begin
          // Seeding: the received stream becomes the LFSR contents.
          r_lfsr     <= {r_lfsr[PRBS_TAP_A-2:0], i_bit};
          r_load_cnt <= (r_load_cnt == LOAD_LAST) ? 4'd0 : r_load_cnt + 4'd1;
          r_win_cnt  <= '0;
          r_win_err  <= '0;
        end else begin
          // Free-running: feed back the prediction so a single received
          // error cannot propagate into later predictions.
          r_lfsr     <= {r_lfsr[PRBS_TAP_A-2:0], w_pred};
          r_load_cnt <= '0;
          if (w_win_end) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_win_err <= w_win_err_tot;
          end
        end
      end
      if (i_clear) begin
        r_err_count <= '0;
        r_bit_count <= '0;
      end else if (w_adv && (r_state == ST_LOCKED)) begin
        if (r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
        if (w_miss && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign o_lock      = (r_state == ST_LOCKED);
  assign o_err_count = r_err_count;
  assign o_bit_count = r_bit_count;

endmodule

// File: rtl/rx_slicer_ber_qi.sv
// rtl/rx_slicer_ber_qi.sv - I/Q decimator, hard slicer and per-channel PRBS9 BER checkers
// Ports:
//   clock, i_reset        : clock, synchronous active-high reset
//   i_enable              : global enable, all state holds when low
//   i_valid               : one oversampled sample per high cycle
//   i_sample_I/Q          : signed filter outputs S(NB_INPUT, NB_INPUT-1)
//   i_phase               : decimation phase select
//   i_clear               : zeroes the error/bit counters only
//   o_bit_valid           : one-cycle pulse per decimated symbol
//   o_bit_I/Q             : sliced bits (negative sample -> 1)
//   o_lock_I/Q            : checker lock per channel
//   o_err_count_I/Q       : bit errors while locked
//   o_bit_count_I/Q       : bits compared while locked
module rx_slicer_ber_qi
  import rx_slicer_ber_qi_pkg::*;
#(
  parameter int NB_INPUT     = 8,
  parameter int OVERSAMPLING = 4,
  parameter int NB_COUNT     = 32,
  parameter int WINDOW       = DEF_WINDOW,
  parameter int LOCK_THR     = DEF_LOCK_THR,
  parameter int LOSS_THR     = DEF_LOSS_THR
) (
  input  logic                              clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic signed [NB_INPUT-1:0]        i_sample_I,
  input  logic signed [NB_INPUT-1:0]        i_sample_Q,
  input  logic [$clog2(OVERSAMPLING)-1:0]   i_phase,
  input  logic                              i_clear,
  output logic                              o_bit_valid,
  output logic                              o_bit_I,
  output logic                              o_bit_Q,
  output logic                              o_lock_I,
  output logic                              o_lock_Q,
  output logic [NB_COUNT-1:0]               o_err_count_I,
  output logic [NB_COUNT-1:0]               o_err_count_Q,
  output logic [NB_COUNT-1:0]               o_bit_count_I,
  output logic [NB_COUNT-1:0]               o_bit_count_Q
);

  localparam int NB_PHASE = $clog2(OVERSAMPLING);

  logic [NB_PHASE-1:0] r_sample_cnt;
  logic                r_bit_valid;
  logic                r_bit_I;
  logic                r_bit_Q;
  logic                w_strobe;
  logic                w_unused;

  // Slicing only needs the sign; the magnitude bits are intentionally ignored.
  assign w_unused = ^{i_sample_I[NB_INPUT-2:0], i_sample_Q[NB_INPUT-2:0]};

  assign w_strobe = i_enable && i_valid && (r_sample_cnt == i_phase);

  // OVERSAMPLING is a power of two, so the counter wraps on its own.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_sample_cnt <= '0;
      r_bit_valid  <= 1'b0;
      r_bit_I      <= 1'b0;
      r_bit_Q      <= 1'b0;
    end else if (i_enable) begin
      if (i_valid) r_sample_cnt <= r_sample_cnt + 1'b1;
      r_bit_valid <= w_strobe;
      if (w_strobe) begin
        r_bit_I <= i_sample_I[NB_INPUT-1];
        r_bit_Q <= i_sample_Q[NB_INPUT-1];
      end
    end
  end

  prbs9_sync_checker #(
    .NB_COUNT (NB_COUNT),
    .WINDOW   (WINDOW),
    .LOCK_THR (LOCK_THR),
    .LOSS_THR (LOSS_THR)
  ) u_chk_I (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_bit       (r_bit_I),
    .i_bit_valid (r_bit_valid),
    .i_clear     (i_clear),
    .o_lock      (o_lock_I),
    .o_err_count (o_err_count_I),
    .o_bit_count (o_bit_count_I)
  );

  prbs9_sync_checker #(
    .NB_COUNT (NB_COUNT),
    .WINDOW   (WINDOW),
    .LOCK_THR (LOCK_THR),
    .LOSS_THR (LOSS_THR)
  ) u_chk_Q (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_bit       (r_bit_Q),
    .i_bit_valid (r_bit_valid),
    .i_clear     (i_clear),
    .o_lock      (o_lock_Q),
    .o_err_count (o_err_count_Q),
    .o_bit_count (o_bit_count_Q)
  );

  assign o_bit_valid = r_bit_valid;
  assign o_bit_I     = r_bit_I;
  assign o_bit_Q     = r_bit_Q;

endmodule

// File: tb/tb_rx_slicer_ber_qi.sv
// tb/tb_rx_slicer_ber_qi.sv - self-checking bench for rx_slicer_ber_qi (32-bit and 8-bit counter builds)
module tb_rx_slicer_ber_qi;

  localparam int OS       = 4;
  localparam int WINDOW   = 128;
  localparam int LOCK_THR = 4;
  localparam int LOSS_THR = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              i_reset, i_enable, i_valid, i_clear;
  logic signed [7:0] i_sample_I, i_sample_Q;
  logic [1:0]        i_phase;

  logic        o_bit_valid_a, o_bit_I_a, o_bit_Q_a, o_lock_I_a, o_lock_Q_a;
  logic [31:0] o_err_count_I_a, o_err_count_Q_a, o_bit_count_I_a, o_bit_count_Q_a;
  logic        o_bit_valid_b, o_bit_I_b, o_bit_Q_b, o_lock_I_b, o_lock_Q_b;
  logic [7:0]  o_err_count_I_b, o_err_count_Q_b, o_bit_count_I_b, o_bit_count_Q_b;

  rx_slicer_ber_qi #(.NB_INPUT(8), .OVERSAMPLING(OS), .NB_COUNT(32)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_sample_I(i_sample_I), .i_sample_Q(i_sample_Q), .i_phase(i_phase), .i_clear(i_clear),
    .o_bit_valid(o_bit_valid_a), .o_bit_I(o_bit_I_a), .o_bit_Q(o_bit_Q_a),
    .o_lock_I(o_lock_I_a), .o_lock_Q(o_lock_Q_a),
    .o_err_count_I(o_err_count_I_a), .o_err_count_Q(o_err_count_Q_a),
    .o_bit_count_I(o_bit_count_I_a), .o_bit_count_Q(o_bit_count_Q_a)
  );

  rx_slicer_ber_qi #(.NB_INPUT(8), .OVERSAMPLING(OS), .NB_COUNT(8)) dut8 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_sample_I(i_sample_I), .i_sample_Q(i_sample_Q), .i_phase(i_phase), .i_clear(i_clear),
    .o_bit_valid(o_bit_valid_b), .o_bit_I(o_bit_I_b), .o_bit_Q(o_bit_Q_b),
    .o_lock_I(o_lock_I_b), .o_lock_Q(o_lock_Q_b),
    .o_err_count_I(o_err_count_I_b), .o_err_count_Q(o_err_count_Q_b),
    .o_bit_count_I(o_bit_count_I_b), .o_bit_count_Q(o_bit_count_Q_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sampling/slicing in plain arithmetic, each checker as a history queue
  // (seed bits then predicted bits) plus per-window tallies.
  int       m_cnt;
  bit       m_valid, m_bI, m_bQ;
  int       m_mode [2];   // 0 acquiring seed, 1 trial window, 2 locked
  int       m_seed_n [2];
  bit       hist [2][$];
  int       wb [2];
  int       we [2];
  longint   m_bits [2];
  longint   m_errs [2];

  task automatic m_reset();
    m_cnt = 0; m_valid = 0; m_bI = 0; m_bQ = 0;
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = 0; m_seed_n[c] = 0; hist[c].delete();
      wb[c] = 0; we[c] = 0; m_bits[c] = 0; m_errs[c] = 0;
    end
  endtask

  task automatic m_feed(input int c, input bit b);
    bit pred;
    if (m_mode[c] == 0) begin
      hist[c].push_back(b);
      if (hist[c].size() > 9) void'(hist[c].pop_front());
      m_seed_n[c]++;
      if (m_seed_n[c] == 9) begin
        m_mode[c] = 1; m_seed_n[c] = 0; wb[c] = 0; we[c] = 0;
      end
    end else begin
      pred = hist[c][0] ^ hist[c][4];   // b[n-9] ^ b[n-5]
      hist[c].push_back(pred);
      void'(hist[c].pop_front());
      if (m_mode[c] == 2) begin
        m_bits[c]++;
        if (pred != b) m_errs[c]++;
      end
      wb[c]++;
      if (pred != b) we[c]++;
      if (wb[c] == WINDOW) begin
        if (m_mode[c] == 1) m_mode[c] = (we[c] <= LOCK_THR) ? 2 : 0;
        else if (we[c] > LOSS_THR) m_mode[c] = 0;
        wb[c] = 0; we[c] = 0;
      end
    end
  endtask

  always @(posedge clock) begin
    bit strobe;
    if (i_reset) m_reset();
    else if (i_enable) begin
      if (m_valid) begin
        m_feed(0, m_bI);
        m_feed(1, m_bQ);
      end
      if (i_clear) begin
        m_bits[0] = 0; m_bits[1] = 0; m_errs[0] = 0; m_errs[1] = 0;
      end
      strobe = i_valid && (m_cnt == int'(i_phase));
      m_valid = strobe;
      if (strobe) begin
        m_bI = (i_sample_I < 0);
        m_bQ = (i_sample_Q < 0);
      end
      if (i_valid) m_cnt = (m_cnt + 1) % OS;
    end
  end

  function automatic logic [63:0] sat8(input longint v);
    return (v > 255) ? 64'd255 : 64'(v);
  endfunction

  always @(negedge clock) begin
    if (run_cmp) begin
      chk("bit_valid",   64'(o_bit_valid_a), 64'(m_valid));
      chk("bit_I",       64'(o_bit_I_a),     64'(m_bI));
      chk("bit_Q",       64'(o_bit_Q_a),     64'(m_bQ));
      chk("lock_I",      64'(o_lock_I_a),    64'(m_mode[0] == 2));
      chk("lock_Q",      64'(o_lock_Q_a),    64'(m_mode[1] == 2));
      chk("err_I",       64'(o_err_count_I_a), 64'(m_errs[0]));
      chk("err_Q",       64'(o_err_count_Q_a), 64'(m_errs[1]));
      chk("bits_I",      64'(o_bit_count_I_a), 64'(m_bits[0]));
      chk("bits_Q",      64'(o_bit_count_Q_a), 64'(m_bits[1]));
      chk("bit_valid_8", 64'(o_bit_valid_b), 64'(m_valid));
      chk("lock_I_8",    64'(o_lock_I_b),    64'(m_mode[0] == 2));
      chk("lock_Q_8",    64'(o_lock_Q_b),    64'(m_mode[1] == 2));
      chk("err_I_8",     64'(o_err_count_I_b), sat8(m_errs[0]));
      chk("err_Q_8",     64'(o_err_count_Q_b), sat8(m_errs[1]));
      chk("bits_I_8",    64'(o_bit_count_I_b), sat8(m_bits[0]));
      chk("bits_Q_8",    64'(o_bit_count_Q_b), sat8(m_bits[1]));
    end
  end

  // Stimulus: PRBS9 sources per channel, x^9 + x^5 + 1, state bit 0 = newest.
  int ps [2];
  int n_sym = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic gen(input int c, output bit b);
    int nb;
    nb = ((ps[c] >> 8) ^ (ps[c] >> 4)) & 1;
    ps[c] = ((ps[c] << 1) | nb) & 511;
    b = nb[0];
  endtask

  task automatic send_sym(input bit bi, input bit bq, input int dphase, input bit noise, input bit clr);
    for (int k = 0; k < OS; k++) begin
      i_valid = 1'b1;
      i_clear = clr && (k == dphase + 1);
      if (k == dphase) begin
        i_sample_I = bi ? 8'hC0 : 8'h40;
        i_sample_Q = bq ? 8'hC0 : 8'h40;
      end else begin
        i_sample_I = noise ? 8'($urandom) : 8'h01;
        i_sample_Q = noise ? 8'($urandom) : 8'h01;
      end
      tick();
    end
    i_clear = 1'b0;
    n_sym++;
    if (n_sym % 5 == 0) begin
      i_valid    = 1'b0;
      i_sample_I = 8'($urandom);
      i_sample_Q = 8'($urandom);
      tick();
    end
  endtask

  task automatic run(input int n, input int dphase, input bit noise, input bit inv_q,
                     input bit flip_first, input bit clr_first);
    bit bi, bq;
    for (int j = 0; j < n; j++) begin
      gen(0, bi);
      gen(1, bq);
      if (j == 0 && flip_first) bi = ~bi;
      send_sym(bi, bq ^ inv_q, dphase, noise, (j == 0) && clr_first);
    end
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    for (int j = 0; j < n; j++) begin
      i_valid = 1'b1;
      i_sample_I = 8'($urandom);
      i_sample_Q = 8'($urandom);
      tick();
    end
    i_reset = 1'b0;
  endtask

  initial begin
    ps[0] = 9'h1FF;
    ps[1] = 9'h0A5;
    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
    i_phase = 2'd0; i_sample_I = '0; i_sample_Q = '0;
    tick();
    run_cmp = 1;
    do_reset(2);
    chk("pin_reset_bits", 64'(o_bit_count_I_a), 64'd0);
    chk("pin_reset_lock", 64'(o_lock_I_a), 64'd0);

    // Clean link: lock needs 9 seed bits + 128 window bits.
    run(136, 0, 0, 0, 0, 0);
    chk("pin_lock_136", 64'(o_lock_I_a), 64'd0);
    run(1, 0, 0, 0, 0, 0);
    chk("pin_lock_137_I", 64'(o_lock_I_a), 64'd1);
    chk("pin_lock_137_Q", 64'(o_lock_Q_a), 64'd1);
    run(10, 0, 0, 0, 0, 0);
    chk("pin_bits_10", 64'(o_bit_count_I_a), 64'd10);
    chk("pin_err_clean", 64'(o_err_count_I_a), 64'd0);

    // Single I error.
    run(4, 0, 0, 0, 1, 0);
    chk("pin_single_err_I", 64'(o_err_count_I_a), 64'd1);
    chk("pin_single_err_Q", 64'(o_err_count_Q_a), 64'd0);
    chk("pin_single_lock", 64'(o_lock_I_a), 64'd1);

    // Saturation of the 8-bit build, then clear coincident with a bit.
    run(260, 0, 0, 0, 0, 0);
    chk("pin_bits_274", 64'(o_bit_count_I_a), 64'd274);
    chk("pin_sat_255", 64'(o_bit_count_I_b), 64'd255);
    run(1, 0, 0, 0, 0, 1);
    chk("pin_clear_a", 64'(o_bit_count_I_a), 64'd0);
    chk("pin_clear_b", 64'(o_bit_count_I_b), 64'd0);
    run(1, 0, 0, 0, 0, 0);
    chk("pin_after_clear", 64'(o_bit_count_Q_b), 64'd1);

    // Reset mid-traffic, then full reacquisition.
    do_reset(3);
    chk("pin_rst_err", 64'(o_err_count_I_a), 64'd0);
    run(136, 0, 0, 0, 0, 0);
    chk("pin_relock_136", 64'(o_lock_I_a), 64'd0);
    run(1, 0, 0, 0, 0, 0);
    chk("pin_relock_137", 64'(o_lock_I_a), 64'd1);

    // Polarity inversion on Q.
    do_reset(1);
    run(300, 0, 0, 1, 0, 0);
    chk("pin_inv_lock_Q", 64'(o_lock_Q_a), 64'd0);
    chk("pin_inv_err_Q", 64'(o_err_count_Q_a), 64'd0);
    chk("pin_inv_lock_I", 64'(o_lock_I_a), 64'd1);

    // Phase select: data only at phase 2.
    do_reset(1);
    i_phase = 2'd2;
    run(140, 2, 1, 0, 0, 0);
    chk("pin_phase2_lock", 64'(o_lock_I_a), 64'd1);
    do_reset(1);
    i_phase = 2'd0;
    run(300, 2, 1, 0, 0, 0);
    chk("pin_phase0_lock_I", 64'(o_lock_I_a), 64'd0);
    chk("pin_phase0_lock_Q", 64'(o_lock_Q_a), 64'd0);

    run_cmp = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
